// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, requester indices and default widths.
package alu_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int unsigned DEF_W  = 32;
    localparam int unsigned DEF_CW = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational; a tie goes to the requester not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two valid/ready requesters, one op in flight at a time.
// Optional grant counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      REQ_VALID,
    output logic [1:0]      REQ_READY,
    input  logic [2*W-1:0]  REQ_A,
    input  logic [2*W-1:0]  REQ_B,
    input  logic [2*CW-1:0] REQ_CTRL,
    output logic [1:0]      RSP_VALID,
    input  logic [1:0]      RSP_READY,
    output logic [W-1:0]    RSP_DATA,
    output logic            RSP_ZERO,
    output logic [W-1:0]    ALU_A,
    output logic [W-1:0]    ALU_B,
    output logic [CW-1:0]   ALU_CTRL,
    input  logic [W-1:0]    ALU_OUT,
    input  logic            ALU_ZERO
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] GNT_CNT0,
    output logic [CNT_W-1:0] GNT_CNT1
`endif
);

    logic [1:0]    state_q, state_d;
    logic          last_gnt_q, cur_q;
    logic [W-1:0]  op_a_q, op_b_q, res_q;
    logic [CW-1:0] op_ctrl_q;
    logic          res_zero_q;
    logic          gnt_valid, gnt_idx;
    logic          accept, rsp_done;

    rr_arbiter2 u_rr (
        .req       (REQ_VALID),
        .last      (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // In IDLE any valid request is granted, so the handshake is just a valid grant.
    assign accept   = (state_q == ST_IDLE) && gnt_valid;
    assign rsp_done = (state_q == ST_RESP) && RSP_READY[cur_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = 2'b00;
        RSP_VALID = 2'b00;
        if (accept) REQ_READY[gnt_idx] = 1'b1;
        if (state_q == ST_RESP) RSP_VALID[cur_q] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= REQ1;
            cur_q      <= REQ0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_ctrl_q  <= '0;
            res_q      <= '0;
            res_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q     <= gnt_idx ? REQ_A[W +: W] : REQ_A[0 +: W];
                op_b_q     <= gnt_idx ? REQ_B[W +: W] : REQ_B[0 +: W];
                op_ctrl_q  <= gnt_idx ? REQ_CTRL[CW +: CW] : REQ_CTRL[0 +: CW];
                cur_q      <= gnt_idx;
                last_gnt_q <= gnt_idx;
            end
            if (state_q == ST_EXEC) begin
                res_q      <= ALU_OUT;
                res_zero_q <= ALU_ZERO;
            end
        end
    end

    assign ALU_A    = op_a_q;
    assign ALU_B    = op_b_q;
    assign ALU_CTRL = op_ctrl_q;
    assign RSP_DATA = res_q;
    assign RSP_ZERO = res_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept && gnt_idx == REQ0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
            if (accept && gnt_idx == REQ1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign GNT_CNT0 = cnt0_q;
    assign GNT_CNT1 = cnt1_q;
`else
    // Grant counters are not built in this configuration.
`endif

endmodule
